target_generator: RTL
=====================

// Module: target_generator
// PURPOSE
//  Produces the red-target grid location (TARGET_ADDR_H/V) consumed by Snake_control and re-rolls it
//  each time Snake_control raises TARGET_REACHED. Two free-running LFSRs supply candidates; rejection
//  sampling keeps targets on the 80x60 grid and off the snake head. Sits upstream of Snake_control.
// PARAMETERS
//  MAX_X        79      last valid horizontal grid cell (8-bit coords)
//  MAX_Y        59      last valid vertical grid cell (7-bit coords)
//  SEED_H       8'h2A   horizontal LFSR reset value, must be non-zero
//  SEED_V       7'h1A   vertical LFSR reset value, must be non-zero
//  RETRY_LIMIT  16      rejected candidates tolerated before fallback placement (>=1)
// PORTS
//  CLK             in   1  system clock
//  RESET           in   1  synchronous, active-high reset
//  MSM_STATE       in   2  master state; 2'b01 = play
//  TARGET_REACHED  in   1  level from Snake_control; rising edge requests a new target
//  SNAKE_HEAD_X    in   8  current head column
//  SNAKE_HEAD_Y    in   7  current head row
//  TARGET_ADDR_H   out  8  target column (registered)
//  TARGET_ADDR_V   out  7  target row (registered)
//  TARGET_VALID    out  1  1 = target address is a settled, accepted placement
//  TARGET_COUNT    out  8  targets taken this game, saturates at 255
// BEHAVIOUR
//  Reset is synchronous, active-high on CLK. On RESET: lfsr_h<=SEED_H, lfsr_v<=SEED_V, state<=ROLL,
//   retry<=0, reached_q<=0, TARGET_ADDR_H<=MAX_X/2, TARGET_ADDR_V<=MAX_Y/2, TARGET_VALID<=0, TARGET_COUNT<=0.
//   RESET mid-ROLL or mid-HOLD behaves identically (restart in ROLL).
//  LFSRs step every non-reset cycle regardless of state.
//   H: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1, period 255. V: 7-bit, x^7+x^6+1, period 127.
//   Candidate in a cycle = current register value (pre-shift); never zero.
//  reached_q <= TARGET_REACHED every cycle; edge = TARGET_REACHED & ~reached_q.
//  msm_q <= MSM_STATE every cycle; new_game = (MSM_STATE==2'b01) & (msm_q!=2'b01).
//  FSM states: ROLL, HOLD.
//   ROLL: accept iff candH<=MAX_X && candV<=MAX_Y && !(candH==SNAKE_HEAD_X && candV==SNAKE_HEAD_Y).
//    accept -> TARGET_ADDR<=cand, TARGET_VALID<=1, retry<=0, -> HOLD.
//    reject && retry==RETRY_LIMIT-1 -> fallback (MAX_X/2, MAX_Y/2); if that equals the head use (0,0);
//     TARGET_VALID<=1, retry<=0, -> HOLD.
//    reject otherwise -> retry<=retry+1, stay ROLL; TARGET_ADDR keeps old value (no glitch), VALID=0.
//   HOLD: edge -> TARGET_VALID<=0, TARGET_COUNT<=sat(+1), -> ROLL.
//    new_game -> TARGET_VALID<=0, TARGET_COUNT<=0, -> ROLL (new_game wins over a same-cycle edge).
//    otherwise hold all outputs.
//  Edges arriving while in ROLL are dropped (not queued); TARGET_COUNT unchanged.
//  new_game in ROLL clears TARGET_COUNT, stays ROLL.
//  Latency: edge sampled in cycle n -> ROLL in n+1 -> earliest new TARGET_ADDR/VALID visible n+2.
//   Worst case n+1+RETRY_LIMIT.
//  Level held high for many cycles yields exactly one re-roll.
//  Widths: compares are unsigned at native width; MAX_X must fit 8 bits, MAX_Y 7 bits; retry is
//   $clog2(RETRY_LIMIT+1) bits. TARGET_COUNT saturates: 255 + edge stays 255.
//  Outside play (MSM_STATE!=01) the FSM still runs; outputs remain valid for rendering.
// STRUCTURE
//  Shared package snake_pkg: GRID_MAX_X=79, GRID_MAX_Y=59, MSM_PLAY=2'b01, coord typedefs
//   (x 8-bit, y 7-bit), target FSM state enum {ROLL, HOLD}.
//  One sub-module: lfsr_fib (params WIDTH, TAPS, SEED; ports CLK, RESET, Q), instantiated twice.
//  Candidate check, fallback mux, edge detect and FSM live in target_generator.
// TESTING
//  T1 defaults, head (10,10), release RESET at c0 -> c1 TARGET_ADDR=(42,26), TARGET_VALID=1, state HOLD.
//  T2 head=(42,26) at reset -> seed candidate rejected, VALID=0 at c1; first accepted value != (42,26),
//   matches golden LFSR model.
//  T3 SEED_H=8'hF0, RETRY_LIMIT=1, head (0,0) -> c1 TARGET_ADDR=(39,29), VALID=1.
//   Same with head=(39,29) -> (0,0).
//  T4 in HOLD, TARGET_REACHED high 10 cycles -> VALID low exactly from n+1; one new target;
//   TARGET_COUNT +1 only.
//  T5 TARGET_COUNT forced to 255 via 255 edges, one more edge -> stays 255;
//   MSM_STATE 00->01 -> count 0, re-roll.
//  T6 RESET asserted mid-ROLL (retrying) -> next cycle seeds reloaded, outputs at reset values;
//   T1 sequence repeats.

Source files
------------

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snake_pkg
//  Description : Shared grid limits, master-state codes, coordinate types and
//                target FSM encoding for the snake game blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    localparam logic [7:0] GRID_MAX_X = 8'd79;
    localparam logic [6:0] GRID_MAX_Y = 7'd59;
    localparam logic [1:0] MSM_PLAY   = 2'b01;

    // Maximal-length feedback masks: x^8+x^6+x^5+x^4+1 and x^7+x^6+1
    localparam logic [7:0] LFSR_H_TAPS = 8'hB8;
    localparam logic [6:0] LFSR_V_TAPS = 7'h60;

    typedef logic [7:0] coord_x_t;
    typedef logic [6:0] coord_y_t;

    typedef enum logic [0:0] {
        ROLL = 1'b0,
        HOLD = 1'b1
    } tgt_state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr_fib.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_fib
//  Description : Free-running Fibonacci LFSR; feedback is the XOR of the
//                TAPS-masked register shifted in at the LSB.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_fib #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = {1'b1, {(WIDTH-1){1'b0}}},
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign Q = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/target_generator.sv
`default_nettype none
// ============================================================================
//  Module      : target_generator
//  Description : Places the red target on the grid by rejection-sampling two
//                LFSRs, re-rolling on each rising edge of TARGET_REACHED.
//  Revision    : 1.0 - initial release
// ============================================================================
module target_generator
    import snake_pkg::*;
#(
    parameter coord_x_t MAX_X       = GRID_MAX_X,
    parameter coord_y_t MAX_Y       = GRID_MAX_Y,
    parameter coord_x_t SEED_H      = 8'h2A,
    parameter coord_y_t SEED_V      = 7'h1A,
    parameter int       RETRY_LIMIT = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] MSM_STATE,
    input  logic       TARGET_REACHED,
    input  logic [7:0] SNAKE_HEAD_X,
    input  logic [6:0] SNAKE_HEAD_Y,
    output logic [7:0] TARGET_ADDR_H,
    output logic [6:0] TARGET_ADDR_V,
    output logic       TARGET_VALID,
    output logic [7:0] TARGET_COUNT
);

    localparam int                 RETRY_W    = $clog2(RETRY_LIMIT + 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_LIMIT - 1);
    localparam coord_x_t           HALF_X     = MAX_X >> 1;
    localparam coord_y_t           HALF_Y     = MAX_Y >> 1;

    coord_x_t cand_h;
    coord_y_t cand_v;

    lfsr_fib #(
        .WIDTH (8),
        .TAPS  (LFSR_H_TAPS),
        .SEED  (SEED_H)
    ) u_lfsr_h (
        .CLK   (CLK),
        .RESET (RESET),
        .Q     (cand_h)
    );

    lfsr_fib #(
        .WIDTH (7),
        .TAPS  (LFSR_V_TAPS),
        .SEED  (SEED_V)
    ) u_lfsr_v (
        .CLK   (CLK),
        .RESET (RESET),
        .Q     (cand_v)
    );

    tgt_state_t         state_q,   state_d;
    logic [RETRY_W-1:0] retry_q,   retry_d;
    logic               reached_q, reached_d;
    logic [1:0]         msm_q,     msm_d;
    coord_x_t           addr_h_q,  addr_h_d;
    coord_y_t           addr_v_q,  addr_v_d;
    logic               valid_q,   valid_d;
    logic [7:0]         count_q,   count_d;

    logic     reach_edge;
    logic     new_game;
    logic     accept;
    logic     fb_on_head;
    coord_x_t fb_h;
    coord_y_t fb_v;

    always_comb begin
        reached_d  = TARGET_REACHED;
        msm_d      = MSM_STATE;
        reach_edge = TARGET_REACHED & ~reached_q;
        new_game   = (MSM_STATE == MSM_PLAY) && (msm_q != MSM_PLAY);

        accept = (cand_h <= MAX_X) && (cand_v <= MAX_Y) &&
                 !((cand_h == SNAKE_HEAD_X) && (cand_v == SNAKE_HEAD_Y));

        // Grid centre unless the head sits there, then the origin corner
        fb_on_head = (HALF_X == SNAKE_HEAD_X) && (HALF_Y == SNAKE_HEAD_Y);
        fb_h       = fb_on_head ? '0 : HALF_X;
        fb_v       = fb_on_head ? '0 : HALF_Y;

        state_d  = state_q;
        retry_d  = retry_q;
        addr_h_d = addr_h_q;
        addr_v_d = addr_v_q;
        valid_d  = valid_q;
        count_d  = count_q;

        case (state_q)
            ROLL: begin
                if (new_game) begin
                    count_d = '0;
                end
                if (accept) begin
                    addr_h_d = cand_h;
                    addr_v_d = cand_v;
                    valid_d  = 1'b1;
                    retry_d  = '0;
                    state_d  = HOLD;
                end else if (retry_q == RETRY_LAST) begin
                    addr_h_d = fb_h;
                    addr_v_d = fb_v;
                    valid_d  = 1'b1;
                    retry_d  = '0;
                    state_d  = HOLD;
                end else begin
                    retry_d = retry_q + RETRY_W'(1);
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (new_game) begin
                    valid_d = 1'b0;
                    count_d = '0;
                    state_d = ROLL;
                end else if (reach_edge) begin
                    valid_d = 1'b0;
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    state_d = ROLL;
                end
            end
            default: begin
                state_d = ROLL;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ROLL;
            retry_q   <= '0;
            reached_q <= 1'b0;
            addr_h_q  <= HALF_X;
            addr_v_q  <= HALF_Y;
            valid_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            retry_q   <= retry_d;
            reached_q <= reached_d;
            addr_h_q  <= addr_h_d;
            addr_v_q  <= addr_v_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
        end
    end

    // Master state is tracked through reset so a held play state never looks new
    always_ff @(posedge CLK) begin
        msm_q <= msm_d;
    end

    assign TARGET_ADDR_H = addr_h_q;
    assign TARGET_ADDR_V = addr_v_q;
    assign TARGET_VALID  = valid_q;
    assign TARGET_COUNT  = count_q;

endmodule
`default_nettype wire
